// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad key codes, the key code type and the
// keypad FSM state encoding, plus a row-pattern decoder used by the scanner.
package calc_pkg;

  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_NONE  = 5'd0;
  localparam key_code_t KEY_DIG0  = 5'd1;
  localparam key_code_t KEY_DIG1  = 5'd2;
  localparam key_code_t KEY_DIG2  = 5'd3;
  localparam key_code_t KEY_DIG3  = 5'd4;
  localparam key_code_t KEY_DIG4  = 5'd5;
  localparam key_code_t KEY_DIG5  = 5'd6;
  localparam key_code_t KEY_DIG6  = 5'd7;
  localparam key_code_t KEY_DIG7  = 5'd8;
  localparam key_code_t KEY_DIG8  = 5'd9;
  localparam key_code_t KEY_DIG9  = 5'd10;
  localparam key_code_t KEY_ADD   = 5'd11;
  localparam key_code_t KEY_SUB   = 5'd12;
  localparam key_code_t KEY_MUL   = 5'd13;
  localparam key_code_t KEY_DIV   = 5'd14;
  localparam key_code_t KEY_ENTER = 5'd15;
  localparam key_code_t KEY_CLEAR = 5'd16;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE
  } kp_state_t;

  // Returns {exactly_one_row_low, row_index}; multi-key patterns count as no key.
  function automatic logic [2:0] decode_rows(input logic [3:0] rows);
    logic [2:0] result;
    result = 3'b000;
    case (rows)
      4'b1110: result = 3'b100;
      4'b1101: result = 3'b101;
      4'b1011: result = 3'b110;
      4'b0111: result = 3'b111;
      default: result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational lookup from keypad (row, column) position to calculator key code.
module keypad_keymap
  import calc_pkg::*;
(
  input  logic [1:0] i_row,
  input  logic [1:0] i_col,
  output key_code_t  o_code
);

  always_comb begin
    o_code = KEY_NONE;
    case ({i_row, i_col})
      4'h0: o_code = KEY_DIG1;
      4'h1: o_code = KEY_DIG2;
      4'h2: o_code = KEY_DIG3;
      4'h3: o_code = KEY_ADD;
      4'h4: o_code = KEY_DIG4;
      4'h5: o_code = KEY_DIG5;
      4'h6: o_code = KEY_DIG6;
      4'h7: o_code = KEY_SUB;
      4'h8: o_code = KEY_DIG7;
      4'h9: o_code = KEY_DIG8;
      4'hA: o_code = KEY_DIG9;
      4'hB: o_code = KEY_MUL;
      4'hC: o_code = KEY_CLEAR;
      4'hD: o_code = KEY_DIG0;
      4'hE: o_code = KEY_ENTER;
      4'hF: o_code = KEY_DIV;
    endcase
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/debouncer producing one key_strobe per accepted press.
// Define KEYPAD_SYNC_EN to add a 2-flop synchronizer on row_sense.
module keypad_encoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int STROBE_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [4:0] value,
  output logic       key_strobe
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(DEBOUNCE_SCANS - 1);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES);

  kp_state_t     r_state, w_state_nxt;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col, w_col_nxt;
  logic [1:0]    r_row, w_row_nxt;
  logic [MW-1:0] r_match, w_match_nxt;
  logic [SW-1:0] r_scnt, w_scnt_nxt;
  key_code_t     r_value, w_value_nxt, w_code;
  logic          r_strobe, w_strobe_nxt;
  logic [3:0]    w_rows;
  logic          w_sample, w_single;
  logic [1:0]    w_row_idx;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= row_sense;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rows = r_sync2;
`else
  assign w_rows = row_sense;
`endif

  assign w_sample                = (r_dwell == DWELL_LAST);
  assign {w_single, w_row_idx}   = decode_rows(w_rows);
  assign col_drive               = ~(4'b0001 << r_col);
  assign value                   = r_value;
  assign key_strobe              = r_strobe;

  keypad_keymap u_keymap (
    .i_row  (r_row),
    .i_col  (r_col),
    .o_code (w_code)
  );

  // Free-running dwell counter keeps every state on the same sample grid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_dwell <= '0;
    else if (w_sample)
      r_dwell <= '0;
    else
      r_dwell <= r_dwell + DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_SCAN;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
      r_match  <= '0;
      r_scnt   <= '0;
      r_value  <= KEY_NONE;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_match  <= w_match_nxt;
      r_scnt   <= w_scnt_nxt;
      r_value  <= w_value_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_match_nxt  = r_match;
    w_scnt_nxt   = r_scnt;
    w_value_nxt  = r_value;
    w_strobe_nxt = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_sample) begin
          if (w_single) begin
            w_row_nxt   = w_row_idx;
            w_match_nxt = MW'(1);
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_sample) begin
          if (w_single && (w_row_idx == r_row)) begin
            if (r_match == MATCH_LAST) begin
              w_value_nxt = w_code;
              w_scnt_nxt  = '0;
              w_state_nxt = ST_STROBE;
            end else begin
              w_match_nxt = r_match + MW'(1);
            end
          end else begin
            w_match_nxt = '0;
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = ST_SCAN;
          end
        end
      end
      // First STROBE cycle only settles value; the pulse starts one cycle later.
      ST_STROBE: begin
        if (r_scnt == STROBE_LAST) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_scnt_nxt   = r_scnt + SW'(1);
          w_strobe_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_sample && (w_rows == 4'b1111)) begin
          w_match_nxt = MW'(1);
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_sample) begin
          if (w_rows == 4'b1111) begin
            if (r_match == MATCH_LAST) begin
              w_value_nxt = KEY_NONE;
              w_match_nxt = '0;
              w_col_nxt   = r_col + 2'd1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_match_nxt = r_match + MW'(1);
            end
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a keypad matrix model drives row_sense,
// presses push expected codes, and a monitor checks every strobe against them.
module tb_keypad_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int STROBE   = 2;
`ifdef KEYPAD_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_sense;
  logic [3:0]  col_drive;
  logic [4:0]  value;
  logic        key_strobe;
  logic [15:0] keyDown = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobeCount = 0;
  int lastRiseCyc = 0;
  int pushed = 0;
  int expQ[$];

  keypad_encoder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .STROBE_CYCLES  (STROBE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .row_sense  (row_sense),
    .col_drive  (col_drive),
    .value      (value),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Physical keypad: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_sense = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyDown[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
  end

  function automatic int keyCode(input int r, input int c);
    if (r < 3 && c < 3) return (r * 3 + c + 1) + 1;
    if (c == 3) return 11 + r;
    if (c == 0) return 16;
    if (c == 1) return 1;
    return 15;
  endfunction

  function automatic logic [15:0] keyBit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  function automatic int nextSample(input int from, input int period, input int phase);
    int n;
    n = from;
    while ((n % period) != phase) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input bit down, input int bounce);
    for (int i = 0; i < bounce; i++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++)
        if (mask[k]) keyDown[k] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (down) keyDown = keyDown | mask;
    else      keyDown = keyDown & ~mask;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValue(input int target, input int budget, output int edgeNum, output bit found);
    found = 1'b0;
    edgeNum = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (value == 5'(target)) begin
        found = 1'b1;
        edgeNum = cyc;
      end
    end
  endtask

  task automatic pushExpected(input int code);
    expQ.push_back(code);
    pushed++;
  endtask

  // Monitor: pops one expected code per strobe rising edge and checks pulse shape.
  initial begin
    bit prevStrobe;
    int width;
    int exp;
    logic [4:0] prevValue;
    prevStrobe = 1'b0;
    width = 0;
    prevValue = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevStrobe = 1'b0;
        width = 0;
      end else begin
        if (key_strobe && !prevStrobe) begin
          strobeCount++;
          lastRiseCyc = cyc;
          width = 1;
          checkOutput("pendingPress", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput("strobeValue", value, exp);
            checkOutput("valueBeforeStrobe", prevValue, exp);
          end
        end else if (key_strobe) begin
          width++;
          checkOutput("valueStableInStrobe", value, prevValue);
        end else if (prevStrobe) begin
          checkOutput("strobeWidth", width, STROBE);
        end
        prevStrobe = key_strobe;
      end
      prevValue = value;
    end
  end

  initial begin
    int p, n, r, m, e, s;
    bit f;
    int rr, cc, bnc;

    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("resetCol", col_drive, 4'b1110);
    checkOutput("resetValue", value, 0);
    checkOutput("resetStrobe", key_strobe, 0);
    reset_n = 1'b1;

    // Clean "7" press: detection timed on the scan grid from reset.
    waitCycles(5);
    pushExpected(keyCode(2, 0));
    applyStimulus(keyBit(2, 0), 1'b1, 0);
    p = cyc;
    n = nextSample(p + 1 + SYNC_DLY, 4 * SCAN_DIV, SCAN_DIV);
    waitValue(keyCode(2, 0), 100, e, f);
    checkOutput("s1Found", f, 1);
    checkOutput("s1PressEdge", e, n + (DEB - 1) * SCAN_DIV);
    waitCycles(3);
    checkOutput("s1StrobeEdge", lastRiseCyc, n + (DEB - 1) * SCAN_DIV + 1);
    waitCycles(190);
    applyStimulus(keyBit(2, 0), 1'b0, 0);
    r = cyc;
    m = nextSample(r + 1 + SYNC_DLY, SCAN_DIV, 0);
    waitValue(0, 100, e, f);
    checkOutput("s1ReleaseFound", f, 1);
    checkOutput("s1ReleaseEdge", e, m + (DEB - 1) * SCAN_DIV);
    waitCycles(40);

    // ENTER with contact bounce.
    s = strobeCount;
    pushExpected(keyCode(3, 2));
    applyStimulus(keyBit(3, 2), 1'b1, 6);
    waitCycles(150);
    applyStimulus(keyBit(3, 2), 1'b0, 0);
    waitCycles(60);
    checkOutput("s2Strobes", strobeCount - s, 1);
    checkOutput("s2Cleared", value, 0);

    // Two keys in column 3 are ignored until one lets go.
    s = strobeCount;
    applyStimulus(keyBit(0, 3) | keyBit(1, 3), 1'b1, 0);
    waitCycles(100);
    checkOutput("s3NoStrobe", strobeCount - s, 0);
    checkOutput("s3ValueIdle", value, 0);
    pushExpected(keyCode(0, 3));
    applyStimulus(keyBit(1, 3), 1'b0, 0);
    waitCycles(60);
    checkOutput("s3HeldValue", value, keyCode(0, 3));
    applyStimulus(keyBit(0, 3), 1'b0, 0);
    waitCycles(60);
    checkOutput("s3Strobes", strobeCount - s, 1);

    // CLEAR held, "0" added during HOLD, both released together.
    s = strobeCount;
    pushExpected(keyCode(3, 0));
    applyStimulus(keyBit(3, 0), 1'b1, 0);
    waitCycles(60);
    applyStimulus(keyBit(3, 1), 1'b1, 0);
    waitCycles(60);
    applyStimulus(keyBit(3, 0) | keyBit(3, 1), 1'b0, 0);
    waitCycles(60);
    checkOutput("s4OneStrobe", strobeCount - s, 1);
    pushExpected(keyCode(3, 1));
    applyStimulus(keyBit(3, 1), 1'b1, 0);
    waitCycles(80);
    checkOutput("s4FreshZero", value, keyCode(3, 1));
    applyStimulus(keyBit(3, 1), 1'b0, 0);
    waitCycles(60);
    checkOutput("s4Strobes", strobeCount - s, 2);

    // Reset during the first strobe cycle, key still held afterwards.
    s = strobeCount;
    pushExpected(keyCode(1, 1));
    applyStimulus(keyBit(1, 1), 1'b1, 0);
    f = 1'b0;
    for (int i = 0; i < 100 && !f; i++) begin
      @(negedge clk);
      f = key_strobe;
    end
    checkOutput("s5StrobeSeen", f, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("s5ResetStrobe", key_strobe, 0);
    checkOutput("s5ResetValue", value, 0);
    checkOutput("s5ResetCol", col_drive, 4'b1110);
    pushExpected(keyCode(1, 1));
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(100);
    checkOutput("s5Redetect", strobeCount - s, 2);
    applyStimulus(keyBit(1, 1), 1'b0, 0);
    waitCycles(60);
    checkOutput("s5Cleared", value, 0);

    // Randomized presses with bounce on both edges.
    for (int t = 0; t < 8; t++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 3);
      bnc = $urandom_range(0, 6);
      pushExpected(keyCode(rr, cc));
      applyStimulus(keyBit(rr, cc), 1'b1, bnc);
      waitCycles($urandom_range(100, 160));
      applyStimulus(keyBit(rr, cc), 1'b0, $urandom_range(0, 6));
      waitCycles(60);
      checkOutput("rndCleared", value, 0);
    end

    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("strobeTotal", strobeCount, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
